// File: rtl/decode_stage.sv
// Decode stage: register file, scoreboard hazard stall and one-entry output slot.
// Optional writeback-to-read forwarding is enabled by defining DECODE_STAGE_BYPASS_EN.
module decode_stage #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3,
    parameter int IMM_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    instruction,
    input  logic [WIDTH-1:0]    pc,
    input  logic [REG_BITS-1:0] sr1,
    input  logic [REG_BITS-1:0] sr2,
    input  logic [REG_BITS-1:0] dr,
    input  logic                sr2_sel,
    input  logic                writes_dr,
    input  logic                flush,
    input  logic                wb_load,
    input  logic [REG_BITS-1:0] wb_dest,
    input  logic [WIDTH-1:0]    wb_data,
    input  logic                ex_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    sr1_out,
    output logic [WIDTH-1:0]    sr2_out,
    output logic [WIDTH-1:0]    sext_out,
    output logic [WIDTH-1:0]    pc_out,
    output logic [REG_BITS-1:0] dr_out,
    output logic                writes_out
);
    localparam int NREGS = 2 ** REG_BITS;

    logic [WIDTH-1:0]    rf_q [NREGS];
    logic [WIDTH-1:0]    rf_d [NREGS];
    logic [NREGS-1:0]    pending_q, pending_d, pending_eff;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    sr1_out_q, sr1_out_d;
    logic [WIDTH-1:0]    sr2_out_q, sr2_out_d;
    logic [WIDTH-1:0]    sext_out_q, sext_out_d;
    logic [WIDTH-1:0]    pc_out_q, pc_out_d;
    logic [REG_BITS-1:0] dr_out_q, dr_out_d;
    logic                writes_out_q, writes_out_d;

    logic [REG_BITS-1:0] rd2;
    logic [WIDTH-1:0]    rd1_val, rd2_val, sext_val;
    logic                hazard, advance, accept;

    always_comb begin
        rd2         = sr2_sel ? dr : sr2;
        pending_eff = pending_q;
        rd1_val     = rf_q[sr1];
        rd2_val     = rf_q[rd2];
`ifdef DECODE_STAGE_BYPASS_EN
        // A register being written back this cycle is already resolved for readers.
        if (wb_load) begin
            pending_eff[wb_dest] = 1'b0;
            if (wb_dest == sr1) rd1_val = wb_data;
            if (wb_dest == rd2) rd2_val = wb_data;
        end
`endif
        sext_val = {{(WIDTH-IMM_BITS){instruction[IMM_BITS-1]}}, instruction[IMM_BITS-1:0]};
        hazard   = in_valid & (pending_eff[sr1] | pending_eff[rd2] | (writes_dr & pending_eff[dr]));
        advance  = ~out_valid_q | ex_ready;
        in_ready = advance & ~hazard & ~flush & ~reset;
        accept   = in_valid & in_ready;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_load) rf_d[wb_dest] = wb_data;

        out_valid_d  = out_valid_q;
        sr1_out_d    = sr1_out_q;
        sr2_out_d    = sr2_out_q;
        sext_out_d   = sext_out_q;
        pc_out_d     = pc_out_q;
        dr_out_d     = dr_out_q;
        writes_out_d = writes_out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = accept;
            if (accept) begin
                sr1_out_d    = rd1_val;
                sr2_out_d    = rd2_val;
                sext_out_d   = sext_val;
                pc_out_d     = pc;
                dr_out_d     = dr;
                writes_out_d = writes_dr;
            end
        end

        // Later assignments win: a new claim on a register beats its writeback release.
        pending_d = pending_q;
        if (wb_load) pending_d[wb_dest] = 1'b0;
        if (flush && out_valid_q && writes_out_q) pending_d[dr_out_q] = 1'b0;
        if (accept && writes_dr) pending_d[dr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
            pending_q    <= '0;
            out_valid_q  <= 1'b0;
            sr1_out_q    <= '0;
            sr2_out_q    <= '0;
            sext_out_q   <= '0;
            pc_out_q     <= '0;
            dr_out_q     <= '0;
            writes_out_q <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            sr1_out_q    <= sr1_out_d;
            sr2_out_q    <= sr2_out_d;
            sext_out_q   <= sext_out_d;
            pc_out_q     <= pc_out_d;
            dr_out_q     <= dr_out_d;
            writes_out_q <= writes_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sr1_out    = sr1_out_q;
    assign sr2_out    = sr2_out_q;
    assign sext_out   = sext_out_q;
    assign pc_out     = pc_out_q;
    assign dr_out     = dr_out_q;
    assign writes_out = writes_out_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed stimulus pushes expected slot contents,
// a monitor pops and compares whenever the slot is handed to execute.
module tb_decode_stage;
    logic        clk, reset, in_valid, in_ready;
    logic [15:0] instruction, pc;
    logic [2:0]  sr1, sr2, dr;
    logic        sr2_sel, writes_dr, flush, wb_load;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        ex_ready, out_valid;
    logic [15:0] sr1_out, sr2_out, sext_out, pc_out;
    logic [2:0]  dr_out;
    logic        writes_out;

`ifdef DECODE_STAGE_BYPASS_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 4;
`endif

    decode_stage #(.WIDTH(16), .REG_BITS(3), .IMM_BITS(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .sr1(sr1), .sr2(sr2), .dr(dr),
        .sr2_sel(sr2_sel), .writes_dr(writes_dr), .flush(flush),
        .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_ready(ex_ready), .out_valid(out_valid),
        .sr1_out(sr1_out), .sr2_out(sr2_out), .sext_out(sext_out), .pc_out(pc_out),
        .dr_out(dr_out), .writes_out(writes_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, s, p;
        logic [2:0]  d;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] ins);
        sx = ins[5] ? {10'h3FF, ins[5:0]} : {10'h000, ins[5:0]};
    endfunction

    task automatic wb(input logic [2:0] d, input logic [15:0] data);
        wb_load = 1'b1; wb_dest = d; wb_data = data;
        @(posedge clk); #1;
        wb_load = 1'b0;
    endtask

    task automatic send(input logic [15:0] ins, input logic [15:0] p,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                        input logic sel, input logic wd,
                        input logic [15:0] ea, input logic [15:0] eb, output int waited);
        exp_t e;
        instruction = ins; pc = p; sr1 = s1; sr2 = s2; dr = d;
        sr2_sel = sel; writes_dr = wd; in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
        end
        if (waited == 30) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: pc %0h not accepted within 30 cycles", p);
            in_valid = 1'b0;
            return;
        end
        e = '{ea, eb, sx(ins), p, d, wd};
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("out_valid_latency", 32'(out_valid), 32'd1);
    endtask

    // Read of register r while it is pending; released by a writeback three cycles later.
    task automatic stall_read(input logic [2:0] r, input logic [15:0] data, input logic [15:0] p);
        int w;
        fork
            send(16'h0001, p, r, 3'd0, 3'd7, 1'b0, 1'b0, data, 16'h0000, w);
            begin
                repeat (3) @(posedge clk);
                #1;
                wb(r, data);
            end
        join
        check("stall_cycles", 32'(w), 32'(STALL));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_output: pc_out %0h with empty scoreboard", pc_out);
                end else begin
                    e = sb.pop_front();
                    check("sr1_out",    32'(sr1_out),    32'(e.a));
                    check("sr2_out",    32'(sr2_out),    32'(e.b));
                    check("sext_out",   32'(sext_out),   32'(e.s));
                    check("pc_out",     32'(pc_out),     32'(e.p));
                    check("dr_out",     32'(dr_out),     32'(e.d));
                    check("writes_out", 32'(writes_out), 32'(e.w));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int w;
        reset = 1'b1; in_valid = 1'b0; instruction = '0; pc = '0;
        sr1 = '0; sr2 = '0; dr = '0; sr2_sel = 1'b0; writes_dr = 1'b0;
        flush = 1'b0; wb_load = 1'b0; wb_dest = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_sr1_out",    32'(sr1_out),    32'd0);
        check("rst_sext_out",   32'(sext_out),   32'd0);
        check("rst_pc_out",     32'(pc_out),     32'd0);
        check("rst_dr_out",     32'(dr_out),     32'd0);
        check("rst_writes_out", 32'(writes_out), 32'd0);
        check("idle_in_ready",  32'(in_ready),   32'd1);
        @(posedge clk); #1;

        // R3 = 0x1234, then read it; back-to-back issues with sign-extension boundaries
        wb(3'd3, 16'h1234);
        send(16'h0005, 16'h0100, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 16'h1234, 16'h0000, w);
        send(16'h0020, 16'h0102, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000, 16'h1234, w);
        check("throughput_wait", 32'(w), 32'd0);
        send(16'h001F, 16'h0104, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h1234, w);
        check("throughput_wait", 32'(w), 32'd0);

        // RAW hazard on R2 released by writeback
        send(16'h0000, 16'h0106, 3'd0, 3'd0, 3'd2, 1'b0, 1'b1, 16'h0000, 16'h0000, w);
        stall_read(3'd2, 16'hBEEF, 16'h0108);

        // Backpressure: slot holds while ex_ready=0
        @(posedge clk); #1;
        ex_ready = 1'b0;
        send(16'h003A, 16'h0200, 3'd3, 3'd0, 3'd6, 1'b0, 1'b0, 16'h1234, 16'h0000, w);
        fork
            send(16'h0002, 16'h0202, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, w);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("hold_in_ready",  32'(in_ready),  32'd0);
                    check("hold_out_valid", 32'(out_valid), 32'd1);
                    check("hold_pc_out",    32'(pc_out),    32'h0200);
                    check("hold_sext_out",  32'(sext_out),  32'hFFFA);
                end
                @(posedge clk); #1;
                ex_ready = 1'b1;
            end
        join
        check("release_wait", 32'(w), 32'd4);

        // Flush of a pending writer to R5 releases the scoreboard
        @(posedge clk); #1;
        ex_ready = 1'b0;
        send(16'h0000, 16'h0300, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 16'h0000, 16'h0000, w);
        void'(sb.pop_back());
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        ex_ready = 1'b1;
        send(16'h0000, 16'h0302, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, w);
        check("post_flush_wait", 32'(w), 32'd0);

        // Set of pending[4] on the same edge as its writeback must win
        fork
            send(16'h0000, 16'h0400, 3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 16'h0000, 16'h0000, w);
            wb(3'd4, 16'h4444);
        join
        stall_read(3'd4, 16'h5555, 16'h0402);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath and register width in bits.
REQ-002 SHALL have parameter REG_BITS, default 3, register index width; register count is 2**REG_BITS.
REQ-003 SHALL have parameter IMM_BITS, default 6, width of the immediate field instruction[IMM_BITS-1:0].
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the fetch-side handshake.
REQ-007 SHALL have ports instruction input WIDTH and pc input WIDTH, the incoming instruction word and its PC.
REQ-008 SHALL have ports sr1, sr2 and dr, inputs of REG_BITS each, the source and destination indices.
REQ-009 SHALL have port sr2_sel, input, 1; when 1, the second read index is dr instead of sr2.
REQ-010 SHALL have port writes_dr, input, 1; when 1, the instruction will write dr.
REQ-011 SHALL have port flush, input, 1, which squashes the output slot.
REQ-012 SHALL have ports wb_load input 1, wb_dest input REG_BITS and wb_data input WIDTH, the register writeback port.
REQ-013 SHALL have ports ex_ready input 1 and out_valid output 1, the execute-side handshake.
REQ-014 SHALL have ports sr1_out, sr2_out, sext_out and pc_out as registered outputs of WIDTH each, plus dr_out (REG_BITS) and writes_out (1).

Function
REQ-015 SHALL hold a register file of 2**REG_BITS by WIDTH; wb_load=1 writes wb_data to wb_dest at the clock edge.
REQ-016 SHALL define advance = !out_valid | ex_ready; the output slot loads only when advance=1.
REQ-017 SHALL keep a scoreboard of one pending bit per register.
REQ-018 SHALL define hazard = in_valid & (pending[sr1] | pending[rd2] | (writes_dr & pending[dr])), where rd2 = sr2_sel ? dr : sr2.
REQ-019 SHALL drive in_ready = advance & !hazard & !flush, combinationally.
REQ-020 SHALL, on accept (in_valid & in_ready), latch the register reads, sext_out, pc, dr and writes_dr into the output slot and set out_valid=1.
REQ-021 SHALL produce sext_out as instruction[IMM_BITS-1:0] sign-extended to WIDTH.
REQ-022 SHALL clear out_valid when advance=1 and no accept occurs; the output slot holds its values while out_valid=1 and ex_ready=0.
REQ-023 SHALL, on accept with writes_dr=1, set pending[dr].
REQ-024 SHALL, on wb_load=1, clear pending[wb_dest]; when the same edge also sets that bit, the set takes priority.
REQ-025 SHALL, on flush=1, clear out_valid, and clear pending[dr_out] if out_valid & writes_out; flush overrides accept.
REQ-026 SHALL keep a writeback to a non-pending register a plain register-file write, with no scoreboard change.
REQ-027 SHALL give a one-cycle accept-to-out_valid latency, with full throughput when there is no hazard and ex_ready=1.

Reset
REQ-028 SHALL, on reset, clear out_valid, writes_out, all pending bits, all registers, and sr1_out, sr2_out, sext_out, pc_out and dr_out to 0.
REQ-029 SHALL let reset override flush, accept and writeback on the same edge; in_ready SHALL be 0 while reset=1.

Configuration
REQ-030 SHALL, with DECODE_STAGE_BYPASS_EN defined, forward wb_data to a read whose index equals wb_dest when wb_load=1, and mask that register's pending bit in hazard.
REQ-031 SHALL, without DECODE_STAGE_BYPASS_EN, read the pre-write register value, with the pending bit stalling until the cycle after writeback.

Verification
REQ-032 SHALL cover: reset, then write R3=0x1234 via wb, then issue sr1=3 -> sr1_out=0x1234 with out_valid one cycle after accept.
REQ-033 SHALL cover: issue writes_dr, dr=2, then sr1=2 next cycle -> in_ready=0 until wb_load with wb_dest=2; data arrives on the same cycle with bypass, or the following cycle without it.
REQ-034 SHALL cover: hold ex_ready=0 with out_valid=1 -> in_ready=0 and outputs stable for 4 cycles; release -> the next instruction is accepted.
REQ-035 SHALL cover: flush with writes_out=1, dr_out=5 -> out_valid=0 next cycle and pending[5]=0; a following read of R5 does not stall.
REQ-036 SHALL cover: instruction[5:0]=0x20, WIDTH=16 -> sext_out=0xFFE0; with 0x1F -> sext_out=0x001F.
REQ-037 SHALL cover: on the same edge, an accept with writes_dr=1, dr=4 and wb_load=1, wb_dest=4 -> pending[4]=1 afterwards.
